// File: rtl/karatsuba_prod_accum.sv
// karatsuba_prod_accum
//
// Purpose:
//   Sits directly downstream of the combinational Karatsuba multiplier and
//   sums a packet of its 2N-bit products (packet end marked by in_last) into
//   a guard-bit-extended accumulator. Each packet's sum is presented on a
//   single-entry registered valid/ready output, together with the number of
//   terms and a sticky overflow flag. Sustains one product beat per cycle,
//   including back-to-back single-beat packets.
//
// Ports:
//   clk        in   1      clock, all state updates on the rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      product beat valid
//   in_ready   out  1      block can accept a beat this cycle
//   in_prod    in   2N     unsigned product from the multiplier
//   in_last    in   1      beat is the final term of the packet
//   out_valid  out  1      packet result held
//   out_ready  in   1      downstream consumes the result
//   out_sum    out  ACC_W  packet sum modulo 2^ACC_W
//   out_cnt    out  CNT_W  terms in packet, saturating at all-ones
//   out_ovf    out  1      some addition in the packet carried out of ACC_W

module karatsuba_prod_accum #(
    parameter int N     = 32,
    parameter int G     = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 2*N + G
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     in_prod,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [CNT_W-1:0]   out_cnt,
    output logic               out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_inc;

    assign accept   = in_valid && in_ready;
    assign prod_ext = {{G{1'b0}}, in_prod};
    // The extra top bit of the sum is the carry out of the ACC_W-bit adder.
    assign sum_ext  = {1'b0, acc} + {1'b0, prod_ext};
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // State register. Reset discards any partial packet and any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A held result consumed in the same cycle as a new
    // beat lets that beat start a packet exactly as it would from idle, which
    // is what keeps single-beat packets flowing at full rate.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = in_last ? S_HOLD : S_ACC;
                end
            end
            S_ACC: begin
                if (accept && in_last) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_next = in_last ? S_HOLD : S_ACC;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs. in_ready depends on out_ready and state only, never
    // on in_valid, so upstream cannot form a combinational loop through us.
    always_comb begin
        in_ready  = (state != S_HOLD) || out_ready;
        out_valid = (state == S_HOLD);
    end

    // Accumulator and result registers. Result registers change only when a
    // packet's last beat is accepted; otherwise they keep the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else if (accept) begin
            if (state == S_ACC) begin
                if (in_last) begin
                    out_sum <= sum_ext[ACC_W-1:0];
                    out_cnt <= cnt_inc;
                    out_ovf <= ovf | sum_ext[ACC_W];
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                end else begin
                    acc <= sum_ext[ACC_W-1:0];
                    cnt <= cnt_inc;
                    ovf <= ovf | sum_ext[ACC_W];
                end
            end else begin
                // Idle, or a held result being consumed: the beat opens a
                // fresh packet.
                if (in_last) begin
                    out_sum <= prod_ext;
                    out_cnt <= CNT_W'(1);
                    out_ovf <= 1'b0;
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                end else begin
                    acc <= prod_ext;
                    cnt <= CNT_W'(1);
                    ovf <= 1'b0;
                end
            end
        end
    end

endmodule
